hazard_ctrl: RTL
================

Name: hazard_ctrl

Overview:
- Pipeline hazard/stall controller for the 5-stage MIPS core. Sits directly downstream of the per-instruction use/new decoder.
- Each cycle it takes the D-stage instruction and its packed use/new word.
- Internally it keeps a pipelined Tnew scoreboard for the E, M and W stages, plus a mult/div busy counter.
- From these it produces the D-stage stall and the forwarding selects for the D and E stages.

Parameters:
MULT_CYCLES, 5, busy cycles loaded for mult/multu
DIV_CYCLES, 10, busy cycles loaded for div/divu

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
d_instr  in  32  D-stage instruction
d_use_new  in  32  packed use/new word for d_instr
flush  in  1  exception flush; kills the E and M entries
stall  out  1  freeze PC/IF-ID, bubble into E (combinational)
fwd_d_rs  out  2  D rs source: 0 GRF, 1 E, 2 M
fwd_d_rt  out  2  D rt source: same encoding
fwd_e_rs  out  2  E rs source: 0 pipe reg, 2 M, 3 W (registered-path decode)
fwd_e_rt  out  2  E rt source: same encoding
md_busy  out  1  mult/div counter nonzero

Behaviour:
- d_use_new fields:
  - [25:21] rs Tuse; 31 means unused.
  - [20:16] rt time; bit1=0 means it is a Tuse, bit1=1 means it is a Tnew for rt. 31 means unused.
  - [15:11] rd Tnew; valid only when bit0=1.
  - bit4: the instruction writes HI/LO (mult/multu/div/divu).
- D destination:
  - Opcode 000011 (jal): dst=31, tnew=0.
  - Else if bit0: dst=rd, tnew=[12:11].
  - Else if bit1: dst=rt, tnew=[17:16].
  - Else no destination.
  - dst=0 is treated as no destination.
- Scoreboard entries E/M/W each hold {dst[4:0], tnew[1:0]}. E additionally holds {rs, rt, md, md_div}.
- Each clock:
  - W <= M with tnew saturating-decremented.
  - M <= E with tnew saturating-decremented.
  - E <= D decode when !stall, else a bubble (dst=0, md=0).
- flush: E and M load a bubble, and W loads the decremented old M. flush has priority over stall.
- reset=0 at a clock edge:
  - All entries become bubbles; md counter=0.
  - Outputs next cycle: stall=0, all fwd=0, md_busy=0. This applies mid-operation too.
- Stall on a register (rs or rt in Tuse role, reg≠0, Tuse≠31): assert when (E.dst==reg && E.tnew>Tuse) || (M.dst==reg && M.tnew>Tuse).
- HI/LO stall:
  - Trigger: D is mfhi/mflo/mthi/mtlo/mult/multu/div/divu (opcode 0, func 010000/010010/010001/010011/0110xx).
  - Stall when (counter≠0 || E.md).
- stall = OR of the rs, rt and HI/LO terms.
- md counter:
  - When E.md and not flush, load DIV_CYCLES if E.md_div, else MULT_CYCLES.
  - Otherwise decrement while nonzero.
  - md_busy = (counter≠0).
- fwd_d_* for reg≠0:
  - 1 if E.dst==reg && E.tnew==0.
  - Else 2 if M.dst==reg && M.tnew==0.
  - Else 0.
  - The GRF provides W→D bypass internally.
- fwd_e_* use the registered E.rs/E.rt, reg≠0:
  - 2 if M.dst==reg && M.tnew==0.
  - Else 3 if W.dst==reg.
  - Else 0.
  - M has priority over W.
- Stall never produces a hazard that forwarding can satisfy: any stall-free case must have a tnew==0 source or a GRF source.

Test Plan:
- lw $1 then add $2,$1,$3 back-to-back:
  - stall=1 for exactly 1 cycle (E.tnew=2>Tuse 1).
  - Then add enters E with fwd_e_rs=3 (W) one cycle later.
- add $1 then beq $1,$0:
  - stall=1 for 1 cycle.
  - Next cycle fwd_d_rs=2 (M, tnew 0), stall=0.
- jal then jr $31 (delay slot nop omitted): fwd_d_rs=1 from E, stall=0.
- mult then mflo immediately:
  - stall held while mult is in E and for MULT_CYCLES=5 counter cycles (6 total).
  - md_busy high exactly 5 cycles.
  - Repeat with div: 11 stalled cycles.
- lw $1 in E with add $2,$1 in D, flush=1 asserted:
  - Next cycle E and M are bubbles, stall=0, fwd all 0.
- reset=0 applied mid div busy: next cycle md_busy=0, stall=0, all entries are bubbles; add $0,… after lw $0 never stalls.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Stall and forwarding control for the 5-stage MIPS pipeline.
// Tracks {dst, tnew} for E/M/W plus a HI/LO busy counter for mult/div.
module hazard_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] d_instr,
    input  logic [31:0] d_use_new,
    input  logic        flush,
    output logic        stall,
    output logic [1:0]  fwd_d_rs,
    output logic [1:0]  fwd_d_rt,
    output logic [1:0]  fwd_e_rs,
    output logic [1:0]  fwd_e_rt,
    output logic        md_busy
);
    localparam int MAX_CYCLES = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    logic [5:0]    d_op;
    logic [4:0]    d_rs, d_rt, d_rd, d_rs_tuse, d_rt_time;
    logic          d_rs_used, d_rt_used, d_hilo;
    logic          stall_rs, stall_rt, stall_hilo;
    logic [4:0]    d_dst;
    logic [1:0]    d_tnew;

    logic [4:0]    e_dst_q, e_rs_q, e_rt_q;
    logic [1:0]    e_tnew_q;
    logic          e_md_q, e_div_q;
    logic [4:0]    m_dst_q;
    logic [1:0]    m_tnew_q;
    logic [4:0]    w_dst_q;
    logic [CW-1:0] md_cnt_q;

    logic unused_bits;
    assign unused_bits = ^{d_instr[10:6], d_instr[0], d_use_new[31:26], d_use_new[15:13],
                           d_use_new[10:5], d_use_new[3:2]};

    function automatic logic [1:0] sat_dec(input logic [1:0] t);
        return (t == 2'd0) ? 2'd0 : t - 2'd1;
    endfunction

    function automatic logic pending(input logic [4:0] r, input logic [4:0] tuse,
                                     input logic [4:0] e_dst, input logic [1:0] e_tnew,
                                     input logic [4:0] m_dst, input logic [1:0] m_tnew);
        return (e_dst == r && {3'b000, e_tnew} > tuse) ||
               (m_dst == r && {3'b000, m_tnew} > tuse);
    endfunction

    function automatic logic [1:0] sel_d(input logic [4:0] r,
                                         input logic [4:0] e_dst, input logic [1:0] e_tnew,
                                         input logic [4:0] m_dst, input logic [1:0] m_tnew);
        if (r == 5'd0)                         return 2'd0;
        if (e_dst == r && e_tnew == 2'd0)      return 2'd1;
        if (m_dst == r && m_tnew == 2'd0)      return 2'd2;
        return 2'd0;
    endfunction

    function automatic logic [1:0] sel_e(input logic [4:0] r,
                                         input logic [4:0] m_dst, input logic [1:0] m_tnew,
                                         input logic [4:0] w_dst);
        if (r == 5'd0)                         return 2'd0;
        if (m_dst == r && m_tnew == 2'd0)      return 2'd2;
        if (w_dst == r)                        return 2'd3;
        return 2'd0;
    endfunction

    assign d_op      = d_instr[31:26];
    assign d_rs      = d_instr[25:21];
    assign d_rt      = d_instr[20:16];
    assign d_rd      = d_instr[15:11];
    assign d_rs_tuse = d_use_new[25:21];
    assign d_rt_time = d_use_new[20:16];

    always_comb begin
        d_dst  = 5'd0;
        d_tnew = 2'd0;
        if (d_op == 6'b000011) begin
            d_dst  = 5'd31;
            d_tnew = 2'd0;
        end else if (d_use_new[0]) begin
            d_dst  = d_rd;
            d_tnew = d_use_new[12:11];
        end else if (d_use_new[1]) begin
            d_dst  = d_rt;
            d_tnew = d_use_new[17:16];
        end
    end

    // rt only acts as a source when its time field is a Tuse (bit1 clear)
    assign d_rs_used  = (d_rs_tuse != 5'd31) && (d_rs != 5'd0);
    assign d_rt_used  = !d_use_new[1] && (d_rt_time != 5'd31) && (d_rt != 5'd0);
    assign d_hilo     = (d_op == 6'd0) &&
                        (d_instr[5:2] == 4'b0100 || d_instr[5:2] == 4'b0110);

    assign stall_rs   = d_rs_used &&
                        pending(d_rs, d_rs_tuse, e_dst_q, e_tnew_q, m_dst_q, m_tnew_q);
    assign stall_rt   = d_rt_used &&
                        pending(d_rt, d_rt_time, e_dst_q, e_tnew_q, m_dst_q, m_tnew_q);
    assign stall_hilo = d_hilo && ((md_cnt_q != '0) || e_md_q);
    assign stall      = stall_rs || stall_rt || stall_hilo;

    assign fwd_d_rs = sel_d(d_rs, e_dst_q, e_tnew_q, m_dst_q, m_tnew_q);
    assign fwd_d_rt = sel_d(d_rt, e_dst_q, e_tnew_q, m_dst_q, m_tnew_q);
    assign fwd_e_rs = sel_e(e_rs_q, m_dst_q, m_tnew_q, w_dst_q);
    assign fwd_e_rt = sel_e(e_rt_q, m_dst_q, m_tnew_q, w_dst_q);
    assign md_busy  = (md_cnt_q != '0);

    always_ff @(posedge clk) begin
        if (!reset) begin
            e_dst_q  <= '0;
            e_tnew_q <= '0;
            e_rs_q   <= '0;
            e_rt_q   <= '0;
            e_md_q   <= 1'b0;
            e_div_q  <= 1'b0;
            m_dst_q  <= '0;
            m_tnew_q <= '0;
            w_dst_q  <= '0;
            md_cnt_q <= '0;
        end else begin
            // M always retires into W, even on flush
            w_dst_q <= m_dst_q;
            if (flush) begin
                m_dst_q  <= '0;
                m_tnew_q <= '0;
            end else begin
                m_dst_q  <= e_dst_q;
                m_tnew_q <= sat_dec(e_tnew_q);
            end
            if (flush || stall) begin
                e_dst_q  <= '0;
                e_tnew_q <= '0;
                e_rs_q   <= '0;
                e_rt_q   <= '0;
                e_md_q   <= 1'b0;
                e_div_q  <= 1'b0;
            end else begin
                e_dst_q  <= d_dst;
                e_tnew_q <= d_tnew;
                e_rs_q   <= d_rs;
                e_rt_q   <= d_rt;
                e_md_q   <= d_use_new[4];
                e_div_q  <= d_use_new[4] & d_instr[1];
            end
            if (e_md_q && !flush)
                md_cnt_q <= e_div_q ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
            else if (md_cnt_q != '0)
                md_cnt_q <= md_cnt_q - 1'b1;
        end
    end
endmodule
